// File: rtl/cache_replace_ctrl.sv
// cache_replace_ctrl: miss/replacement FSM between tag arrays, PLRU and memory; CACHE_PERF_CNT_EN adds hit/miss counters
//   i_clk, i_rst (async, active-high); i_req/i_index: held CPU request; i_hit_vec/i_valid_vec/i_dirty_vec: indexed set state
//   i_lru_way: PLRU victim; i_pmem_resp: memory done pulse; o_resp: request complete; o_mru_way/o_mru_load: PLRU update
//   o_victim_way: registered victim; o_pmem_read/o_pmem_write: fill/writeback; o_fill_load: line install; o_busy; o_hit_count/o_miss_count
module cache_replace_ctrl #(
  parameter int SETS = 8,
  parameter int ASSOCIATIVITY = 2,
  localparam int W = $clog2(ASSOCIATIVITY)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req,
  input  logic [$clog2(SETS)-1:0]  i_index,
  input  logic [ASSOCIATIVITY-1:0] i_hit_vec,
  input  logic [ASSOCIATIVITY-1:0] i_valid_vec,
  input  logic [ASSOCIATIVITY-1:0] i_dirty_vec,
  input  logic [W-1:0]             i_lru_way,
  input  logic                     i_pmem_resp,
  output logic                     o_resp,
  output logic [W-1:0]             o_mru_way,
  output logic                     o_mru_load,
  output logic [W-1:0]             o_victim_way,
  output logic                     o_pmem_read,
  output logic                     o_pmem_write,
  output logic                     o_fill_load,
  output logic                     o_busy,
  output logic [31:0]              o_hit_count,
  output logic [31:0]              o_miss_count
);
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_victim_way, w_hit_way, w_inv_way, w_victim;
  logic w_hit, w_miss, w_dirty_victim, w_unused;
  assign w_unused = ^i_index;
  // Downward scan so the lowest matching index is the last assignment and wins.
  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
      if (i_hit_vec[i]) w_hit_way = W'(i);
      if (!i_valid_vec[i]) w_inv_way = W'(i);
    end
  end
  assign w_hit = |i_hit_vec;
  assign w_miss = (r_state == IDLE) & i_req & ~w_hit;
  assign w_victim = &i_valid_vec ? i_lru_way : w_inv_way;
  assign w_dirty_victim = i_valid_vec[w_victim] & i_dirty_vec[w_victim];
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_miss ? (w_dirty_victim ? WB : FILL) : IDLE;
      WB:      w_next = i_pmem_resp ? FILL : WB;
      FILL:    w_next = i_pmem_resp ? IDLE : FILL;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_victim_way <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_victim_way <= w_victim;
    end
  end
  assign o_resp = (r_state == IDLE) & i_req & w_hit;
  assign o_mru_load = o_resp;
  assign o_mru_way = o_resp ? w_hit_way : '0;
  assign o_victim_way = r_victim_way;
  assign o_pmem_write = r_state == WB;
  assign o_pmem_read = r_state == FILL;
  assign o_fill_load = (r_state == FILL) & i_pmem_resp;
  assign o_busy = r_state != IDLE;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] r_hit_count, r_miss_count;
  logic r_missed;
  // r_missed marks the request in flight so its completion hit is not counted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit_count <= '0;
      r_miss_count <= '0;
      r_missed <= 1'b0;
    end else begin
      if (w_miss) r_missed <= 1'b1;
      else if (o_resp) r_missed <= 1'b0;
      if (o_resp && !r_missed && r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
      if (w_miss && r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
    end
  end
  assign o_hit_count = r_hit_count;
  assign o_miss_count = r_miss_count;
`else
  assign o_hit_count = '0;
  assign o_miss_count = '0;
`endif
endmodule
